// File: rtl/fsm_detector_mealey.sv
// Mealy serial pattern detector. The next-state table is built at elaboration
// from PATTERN using KMP-style fallback; the detect flag is combinational.
module fsm_detector_mealey #(
  parameter int                       PATTERN_WIDTH = 3,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 3'b101,
  parameter bit                       OVERLAP       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int SW    = $clog2(PATTERN_WIDTH);
  localparam int TBL_W = 2 * PATTERN_WIDTH * SW;

  // State k = number of pattern bits matched so far.
  typedef logic [SW-1:0] state_t;

  localparam state_t LAST = state_t'(PATTERN_WIDTH - 1);

  // Entry (2*k + b) holds the successor of state k on input bit b: the longest
  // suffix of (matched prefix, b) that is still a prefix, capped below a full match.
  function automatic logic [TBL_W-1:0] build_table();
    logic [TBL_W-1:0]         tbl;
    logic [PATTERN_WIDTH-1:0] seq;
    int                       best;
    bit                       ok;
    tbl = '0;
    for (int k = 0; k < PATTERN_WIDTH; k++) begin
      for (int b = 0; b < 2; b++) begin
        seq = '0;
        for (int j = 0; j < k; j++) seq[j] = PATTERN[PATTERN_WIDTH-1-j];
        seq[k] = b[0];
        best = 0;
        for (int l = 1; (l <= k + 1) && (l < PATTERN_WIDTH); l++) begin
          ok = 1'b1;
          for (int i = 0; i < l; i++)
            if (seq[k+1-l+i] != PATTERN[PATTERN_WIDTH-1-i]) ok = 1'b0;
          if (ok) best = l;
        end
        if (!OVERLAP && (k == PATTERN_WIDTH - 1) && (b[0] == PATTERN[0])) best = 0;
        tbl[(2*k+b)*SW +: SW] = state_t'(best);
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_table();

  state_t state_q;
  state_t state_d;
  int     tbl_idx;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = '0;
    tbl_idx = 0;
    if (state_q <= LAST) begin
      tbl_idx = (2 * int'(state_q) + int'(in)) * SW;
      state_d = NEXT_TBL[tbl_idx +: SW];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign out = ~reset & (state_q == LAST) & (in == PATTERN[0]);

endmodule

// File: tb/tb_fsm_detector_mealey.sv
// Bench for fsm_detector_mealey: three instances (101 overlap, 101 non-overlap,
// 1101 overlap) checked against directed vectors and a string-matching model.
module tb_fsm_detector_mealey;

  logic clk = 1'b0;
  logic reset_s = 1'b1;
  logic in_s = 1'b0;
  logic out_ov, out_no, out_alt;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  fsm_detector_mealey u_ov (
    .clk(clk), .reset(reset_s), .in(in_s), .out(out_ov)
  );
  fsm_detector_mealey #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_no (
    .clk(clk), .reset(reset_s), .in(in_s), .out(out_no)
  );
  fsm_detector_mealey #(.PATTERN_WIDTH(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_alt (
    .clk(clk), .reset(reset_s), .in(in_s), .out(out_alt)
  );

  // Reference model: bits received since reset (or since the last detection
  // when overlap is off); a detection is "history ends with the pattern".
  bit hist_ov[$];
  bit hist_no[$];
  bit hist_alt[$];
  bit exp_ov, exp_no, exp_alt;

  function automatic bit ends_with(input bit q[$], input bit b, input bit r,
                                   input logic [15:0] pat, input int w);
    bit s[$];
    int n;
    if (r) return 1'b0;
    s = q;
    s.push_back(b);
    n = s.size();
    if (n < w) return 1'b0;
    for (int j = 0; j < w; j++)
      if (s[n-w+j] != pat[w-1-j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void compute_exp();
    exp_ov  = ends_with(hist_ov,  in_s, reset_s, 16'b101,  3);
    exp_no  = ends_with(hist_no,  in_s, reset_s, 16'b101,  3);
    exp_alt = ends_with(hist_alt, in_s, reset_s, 16'b1101, 4);
  endfunction

  always @(posedge clk) begin
    if (reset_s) begin
      hist_ov.delete(); hist_no.delete(); hist_alt.delete();
    end else begin
      bit det_no;
      det_no = ends_with(hist_no, in_s, 1'b0, 16'b101, 3);
      hist_ov.push_back(in_s);
      hist_alt.push_back(in_s);
      if (det_no) hist_no.delete();
      else        hist_no.push_back(in_s);
      while (hist_ov.size() > 16)  void'(hist_ov.pop_front());
      while (hist_alt.size() > 16) void'(hist_alt.pop_front());
      while (hist_no.size() > 16)  void'(hist_no.pop_front());
    end
  end

  // Apply one bit on the falling edge, then settle so outputs can be sampled.
  task automatic drive(input bit b, input bit r);
    @(negedge clk);
    in_s = b;
    reset_s = r;
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    checks++;
    if (out_ov !== 1'b0 || out_no !== 1'b0 || out_alt !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out=%b/%b/%b expected 0/0/0", out_ov, out_no, out_alt);
    end
    drive(1'b1, 1'b0);
    checks++;
    if (out_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out=%b expected 0", out_ov);
    end
  endtask

  task automatic test_overlap_stream();
    bit stream[34] = '{0,1,0,1,0,1,0,0,1,1,0,1,0,1,0,0,0,0,1,0,1,0,1,0,0,1,1,0,1,0,0,0,1,0};
    bit hit[34];
    foreach (hit[i]) hit[i] = 1'b0;
    hit[3] = 1; hit[5] = 1; hit[11] = 1; hit[13] = 1; hit[20] = 1; hit[22] = 1; hit[28] = 1;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      drive(stream[i], 1'b0);
      checks++;
      if (out_ov !== hit[i]) begin
        errors++;
        $display("FAIL overlap_stream bit %0d: out=%b expected %b", i + 1, out_ov, hit[i]);
      end
    end
  endtask

  task automatic test_mealy_timing();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (out_ov !== 1'b0) begin
      errors++;
      $display("FAIL mealy_s2_in0: out=%b expected 0", out_ov);
    end
    #2 in_s = 1'b1;
    #1;
    checks++;
    if (out_ov !== 1'b1) begin
      errors++;
      $display("FAIL mealy_rise_midcycle: out=%b expected 1", out_ov);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_ov !== 1'b0) begin
      errors++;
      $display("FAIL mealy_fall_after_edge: out=%b expected 0", out_ov);
    end
  endtask

  task automatic test_non_overlap();
    bit stream[5] = '{1,0,1,0,1};
    bit hit[5]    = '{0,0,1,0,0};
    drive(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(stream[i], 1'b0);
      checks++;
      if (out_no !== hit[i]) begin
        errors++;
        $display("FAIL non_overlap bit %0d: out=%b expected %b", i + 1, out_no, hit[i]);
      end
    end
  endtask

  task automatic test_reset_mid_match();
    bit stream[5] = '{0,1,1,0,1};
    bit hit[5]    = '{0,0,0,0,1};
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    checks++;
    if (out_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_forces_out: out=%b expected 0", out_ov);
    end
    for (int i = 0; i < 5; i++) begin
      drive(stream[i], 1'b0);
      checks++;
      if (out_ov !== hit[i]) begin
        errors++;
        $display("FAIL reset_mid_match bit %0d: out=%b expected %b", i + 1, out_ov, hit[i]);
      end
    end
  endtask

  task automatic test_alt_pattern();
    bit stream[7] = '{1,1,0,1,1,0,1};
    bit hit[7]    = '{0,0,0,1,0,0,1};
    drive(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(stream[i], 1'b0);
      checks++;
      if (out_alt !== hit[i]) begin
        errors++;
        $display("FAIL alt_pattern bit %0d: out=%b expected %b", i + 1, out_alt, hit[i]);
      end
    end
  endtask

  task automatic test_random();
    drive(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(1, 0)), ($urandom_range(39, 0) == 0));
      checks++;
      if (out_ov !== exp_ov || out_no !== exp_no || out_alt !== exp_alt) begin
        errors++;
        $display("FAIL random cycle %0d: out=%b/%b/%b expected %b/%b/%b",
                 cycle, out_ov, out_no, out_alt, exp_ov, exp_no, exp_alt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_stream();
    test_mealy_timing();
    test_non_overlap();
    test_reset_mid_match();
    test_alt_pattern();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
